// File: rtl/apb_upio_gen_if.sv
// APB bus bundle for the user-I/O peripheral.
// The master drives request signals; the slave returns data, ready and error.
interface apb_upio_gen_if #(
    parameter int ADDR_WIDTH = 12
) ();
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [31:0]           PWDATA;
    logic                  PWRITE;
    logic                  PSEL;
    logic                  PENABLE;
    logic [31:0]           PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_upio_gen.sv
// Zero-wait-state APB GPIO block with per-pin synchroniser, debounce filter and
// W1C edge-interrupt status combined into one registered interrupt line.
module apb_upio_gen #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_PINS       = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int DEB_WIDTH      = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    apb_upio_gen_if.slave       apb,
    input  logic [NUM_PINS-1:0] upio_in_i,
    output logic [NUM_PINS-1:0] upio_out_o,
    output logic [NUM_PINS-1:0] upio_dir_o,
    output logic                int_o
);
    typedef enum logic [3:0] {
        REG_DIR     = 4'h0,
        REG_OUT     = 4'h1,
        REG_IN      = 4'h2,
        REG_SET     = 4'h3,
        REG_CLR     = 4'h4,
        REG_RISE_EN = 4'h5,
        REG_FALL_EN = 4'h6,
        REG_STATUS  = 4'h7,
        REG_DEB_CNT = 4'h8
    } reg_e;

    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [NUM_PINS-1:0]       wdata;
    logic                      access;
    logic [31:0]               rdata;
    logic                      slverr;
    logic                      unused_bits;

    logic [NUM_PINS-1:0]  dir_q, dir_d;
    logic [NUM_PINS-1:0]  out_q, out_d;
    logic [NUM_PINS-1:0]  rise_en_q, rise_en_d;
    logic [NUM_PINS-1:0]  fall_en_q, fall_en_d;
    logic [NUM_PINS-1:0]  status_q, status_d;
    logic [DEB_WIDTH-1:0] deb_cnt_q, deb_cnt_d;
    logic                 deb_wr;
    logic [NUM_PINS-1:0]  w1c;

    logic [NUM_PINS-1:0]  sync_q [SYNC_STAGES];
    logic [NUM_PINS-1:0]  sync_in;
    logic [NUM_PINS-1:0]  filt_q, filt_d;
    logic [NUM_PINS-1:0]  filt_prev_q;
    logic [DEB_WIDTH-1:0] cnt_q [NUM_PINS];
    logic [DEB_WIDTH-1:0] cnt_d [NUM_PINS];
    logic [NUM_PINS-1:0]  rise, fall;
    logic                 int_q;

    assign paddr       = apb.PADDR;
    assign wdata       = apb.PWDATA[NUM_PINS-1:0];
    assign access      = apb.PSEL & apb.PENABLE;
    assign sync_in     = sync_q[SYNC_STAGES-1];
    assign unused_bits = ^{paddr, apb.PWDATA};

    assign apb.PRDATA  = rdata;
    assign apb.PSLVERR = slverr;
    assign apb.PREADY  = 1'b1;
    assign upio_out_o  = out_q;
    assign upio_dir_o  = dir_q;
    assign int_o       = int_q;

    // Register decode: read mux and write next-state in one place.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        rdata     = '0;
        slverr    = 1'b0;
        dir_d     = dir_q;
        out_d     = out_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        deb_cnt_d = deb_cnt_q;
        deb_wr    = 1'b0;
        w1c       = '0;
        if (access) begin
            case (paddr[5:2])
                REG_DIR: begin
                    rdata = 32'(dir_q);
                    if (apb.PWRITE) dir_d = wdata;
                end
                REG_OUT: begin
                    rdata = 32'(out_q);
                    if (apb.PWRITE) out_d = wdata;
                end
                REG_IN:  rdata = 32'(filt_q);
                REG_SET: if (apb.PWRITE) out_d = out_q | wdata;
                REG_CLR: if (apb.PWRITE) out_d = out_q & ~wdata;
                REG_RISE_EN: begin
                    rdata = 32'(rise_en_q);
                    if (apb.PWRITE) rise_en_d = wdata;
                end
                REG_FALL_EN: begin
                    rdata = 32'(fall_en_q);
                    if (apb.PWRITE) fall_en_d = wdata;
                end
                REG_STATUS: begin
                    rdata = 32'(status_q);
                    if (apb.PWRITE) w1c = wdata;
                end
                REG_DEB_CNT: begin
                    rdata = 32'(deb_cnt_q);
                    if (apb.PWRITE) begin
                        deb_cnt_d = apb.PWDATA[DEB_WIDTH-1:0];
                        deb_wr    = 1'b1;
                    end
                end
                default: slverr = 1'b1;
            endcase
        end
    end

    // Debounce: a pin must disagree with filt for DEB_CNT+1 cycles before filt flips.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < NUM_PINS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_in[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == deb_cnt_q) begin
                filt_d[i] = sync_in[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
            if (deb_wr) cnt_d[i] = '0;
        end
        rise     = filt_q & ~filt_prev_q & rise_en_q;
        fall     = ~filt_q & filt_prev_q & fall_en_q;
        status_d = (status_q & ~w1c) | rise | fall;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dir_q       <= '0;
            out_q       <= '0;
            rise_en_q   <= '0;
            fall_en_q   <= '0;
            status_q    <= '0;
            deb_cnt_q   <= '0;
            filt_q      <= '0;
            filt_prev_q <= '0;
            int_q       <= 1'b0;
            // NOTE: these arrays are plain flops, not RAM, so clearing them in reset is legal and required.
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            for (int i = 0; i < NUM_PINS; i++) cnt_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            dir_q       <= dir_d;
            out_q       <= out_d;
            rise_en_q   <= rise_en_d;
            fall_en_q   <= fall_en_d;
            status_q    <= status_d;
            deb_cnt_q   <= deb_cnt_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            int_q       <= |status_q;
            sync_q[0]   <= upio_in_i;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            for (int i = 0; i < NUM_PINS; i++) cnt_q[i] <= cnt_d[i];
        end
    end
endmodule

// File: tb/tb_apb_upio_gen.sv
// Directed bench for apb_upio_gen: an 8-pin instance for register, debounce and
// W1C behaviour, and a 32-pin instance for reset-mid-activity and bit-31 edges.
module tb_apb_upio_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8, rst32;
    logic [7:0]  pin8, out8, dir8;
    logic [31:0] pin32, out32, dir32;
    logic        int8, int32;
    int          checks = 0;
    int          failures = 0;

    apb_upio_gen_if #(.ADDR_WIDTH(12)) bus8 ();
    apb_upio_gen_if #(.ADDR_WIDTH(12)) bus32 ();

    apb_upio_gen #(.APB_ADDR_WIDTH(12), .NUM_PINS(8), .SYNC_STAGES(2), .DEB_WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst8), .apb(bus8),
        .upio_in_i(pin8), .upio_out_o(out8), .upio_dir_o(dir8), .int_o(int8)
    );

    apb_upio_gen #(.APB_ADDR_WIDTH(12), .NUM_PINS(32), .SYNC_STAGES(2), .DEB_WIDTH(8)) dut32 (
        .clk_i(clk), .rst_i(rst32), .apb(bus32),
        .upio_in_i(pin32), .upio_out_o(out32), .upio_dir_o(dir32), .int_o(int32)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic sel, input logic en, input logic wr,
                         input logic [11:0] a, input logic [31:0] w);
        if (d == 0) begin
            bus8.PSEL = sel; bus8.PENABLE = en; bus8.PWRITE = wr; bus8.PADDR = a; bus8.PWDATA = w;
        end else begin
            bus32.PSEL = sel; bus32.PENABLE = en; bus32.PWRITE = wr; bus32.PADDR = a; bus32.PWDATA = w;
        end
    endtask

    task automatic sample(input int d, output logic [31:0] rd, output logic err);
        if (d == 0) begin
            rd = bus8.PRDATA; err = bus8.PSLVERR;
        end else begin
            rd = bus32.PRDATA; err = bus32.PSLVERR;
        end
    endtask

    task automatic apb_write(input int d, input logic [11:0] a, input logic [31:0] w);
        drive(d, 1'b1, 1'b0, 1'b1, a, w);
        tick(1);
        drive(d, 1'b1, 1'b1, 1'b1, a, w);
        tick(1);
        drive(d, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic apb_read(input int d, input logic [11:0] a, input logic [31:0] exp,
                            input logic exp_err, input string tag);
        logic [31:0] rd;
        logic        err;
        drive(d, 1'b1, 1'b0, 1'b0, a, '0);
        tick(1);
        drive(d, 1'b1, 1'b1, 1'b0, a, '0);
        #1;
        sample(d, rd, err);
        check({tag, "_data"}, rd, exp);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        tick(1);
        drive(d, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Holds the access phase on a read so PRDATA can be observed mid-cycle.
    task automatic peek(input int d, input logic [11:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        logic        err;
        drive(d, 1'b1, 1'b1, 1'b0, a, '0);
        #1;
        sample(d, rd, err);
        check(tag, rd, exp);
    endtask

    initial begin
        rst8 = 1'b1; rst32 = 1'b1; pin8 = '0; pin32 = '0;
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
        tick(3);
        rst8 = 1'b0; rst32 = 1'b0;

        check("rst_out", 32'(out8), 32'h0);
        check("rst_dir", 32'(dir8), 32'h0);
        check("rst_int", 32'(int8), 32'h0);
        check("idle_prdata", bus8.PRDATA, 32'h0);
        check("idle_pslverr", 32'(bus8.PSLVERR), 32'h0);
        check("pready", 32'(bus8.PREADY), 32'h1);
        for (int i = 0; i < 9; i++) apb_read(0, 12'(i * 4), 32'h0, 1'b0, "rst_reg");
        apb_read(0, 12'h024, 32'h0, 1'b1, "unmapped");

        // OUT / SET / CLR / DIR
        apb_write(0, 12'h004, 32'hA5);
        check("out_wr", 32'(out8), 32'hA5);
        apb_write(0, 12'h00C, 32'h0F);
        check("out_set", 32'(out8), 32'hAF);
        apb_write(0, 12'h010, 32'h81);
        check("out_clr", 32'(out8), 32'h2E);
        apb_write(0, 12'h000, 32'hFF);
        check("dir_wr", 32'(dir8), 32'hFF);
        apb_write(0, 12'h024, 32'hFF);
        apb_read(0, 12'h004, 32'h2E, 1'b0, "out_rd");
        apb_read(0, 12'h00C, 32'h0, 1'b0, "set_rd");
        apb_read(0, 12'h010, 32'h0, 1'b0, "clr_rd");

        // Debounced rise on pin0: IN after SYNC_STAGES+4 edges, STATUS +1, int_o +1
        apb_write(0, 12'h020, 32'd3);
        apb_write(0, 12'h014, 32'h01);
        apb_read(0, 12'h020, 32'd3, 1'b0, "deb_rd");
        pin8[0] = 1'b1;
        tick(5);
        peek(0, 12'h008, 32'h00, "in_early");
        tick(1);
        peek(0, 12'h008, 32'h01, "in_latency");
        peek(0, 12'h01C, 32'h00, "st_early");
        tick(1);
        peek(0, 12'h01C, 32'h01, "st_set");
        check("int_early", 32'(int8), 32'h0);
        tick(1);
        check("int_set", 32'(int8), 32'h1);
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        apb_write(0, 12'h01C, 32'h01);
        check("int_hold", 32'(int8), 32'h1);
        tick(1);
        check("int_fall", 32'(int8), 32'h0);

        // Glitch of 3 synchronised cycles with DEB_CNT=3 is filtered out
        apb_write(0, 12'h014, 32'h02);
        apb_write(0, 12'h018, 32'h02);
        pin8[1] = 1'b1;
        tick(3);
        pin8[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("glitch_int", 32'(int8), 32'h0);
        end
        apb_read(0, 12'h008, 32'h01, 1'b0, "glitch_in");
        apb_read(0, 12'h01C, 32'h00, 1'b0, "glitch_st");

        // W1C racing a new fall on pin2: the set wins
        apb_write(0, 12'h014, 32'h04);
        apb_write(0, 12'h018, 32'h04);
        apb_write(0, 12'h020, 32'd0);
        pin8[2] = 1'b1;
        tick(6);
        apb_read(0, 12'h01C, 32'h04, 1'b0, "st_rise2");
        check("int_rise2", 32'(int8), 32'h1);
        apb_write(0, 12'h014, 32'h00);
        apb_read(0, 12'h01C, 32'h04, 1'b0, "st_keep");
        pin8[2] = 1'b0;
        tick(2);
        apb_write(0, 12'h01C, 32'h04);
        check("int_race", 32'(int8), 32'h1);
        apb_read(0, 12'h01C, 32'h04, 1'b0, "st_race");
        check("int_race2", 32'(int8), 32'h1);
        apb_write(0, 12'h01C, 32'h04);
        check("int_w1c_hold", 32'(int8), 32'h1);
        tick(1);
        check("int_w1c_fall", 32'(int8), 32'h0);
        apb_read(0, 12'h01C, 32'h00, 1'b0, "st_cleared");

        // 32-pin instance: full-width OUT/DIR, then reset mid-activity
        apb_write(1, 12'h004, 32'h8000_0000);
        check("out32_wr", out32, 32'h8000_0000);
        apb_write(1, 12'h00C, 32'h0000_0001);
        check("out32_set", out32, 32'h8000_0001);
        apb_write(1, 12'h010, 32'h8000_0000);
        check("out32_clr", out32, 32'h0000_0001);
        apb_write(1, 12'h000, 32'hFFFF_FFFF);
        check("dir32_wr", dir32, 32'hFFFF_FFFF);
        apb_write(1, 12'h014, 32'hFFFF_FFFF);
        apb_write(1, 12'h018, 32'hFFFF_FFFF);
        for (int i = 0; i < 8; i++) begin
            pin32 = (i % 2 == 1) ? 32'h5555_5555 : 32'hAAAA_AAAA;
            tick(1);
        end
        check("int32_busy", 32'(int32), 32'h1);
        rst32 = 1'b1;
        pin32 = ~pin32;
        tick(1);
        rst32 = 1'b0;
        check("rst32_out", out32, 32'h0);
        check("rst32_dir", dir32, 32'h0);
        check("rst32_int", 32'(int32), 32'h0);
        for (int i = 0; i < 4; i++) begin
            pin32 = ~pin32;
            tick(1);
        end
        pin32 = '0;
        tick(6);
        apb_read(1, 12'h01C, 32'h0, 1'b0, "rst32_st");
        apb_read(1, 12'h014, 32'h0, 1'b0, "rst32_rise_en");
        check("rst32_int_after", 32'(int32), 32'h0);

        // Bit-31 edges with DEB_CNT=0
        apb_write(1, 12'h014, 32'h8000_0000);
        apb_write(1, 12'h018, 32'h8000_0000);
        pin32[31] = 1'b1;
        tick(2);
        peek(1, 12'h008, 32'h0, "in31_early");
        tick(1);
        peek(1, 12'h008, 32'h8000_0000, "in31_set");
        peek(1, 12'h01C, 32'h0, "st31_early");
        tick(1);
        peek(1, 12'h01C, 32'h8000_0000, "st31_rise");
        check("int31_early", 32'(int32), 32'h0);
        tick(1);
        check("int31_set", 32'(int32), 32'h1);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
        apb_write(1, 12'h01C, 32'h8000_0000);
        tick(1);
        check("int31_clr", 32'(int32), 32'h0);
        pin32[31] = 1'b0;
        tick(4);
        apb_read(1, 12'h01C, 32'h8000_0000, 1'b0, "st31_fall");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/apb_upio_gen.md
# apb_upio_gen

Parametrised successor of the user-plugin APB GPIO peripheral. It exposes NUM_PINS bidirectional user I/O pins through a zero-wait-state APB slave. Each input goes through a synchroniser and a per-pin programmable debounce filter. Per-pin rising and falling edge interrupts are latched into a W1C status register and combined into one interrupt line that feeds the plugin's event/interrupt output.

## Interface
Parameters:
- APB_ADDR_WIDTH, 12, APB address width; only PADDR[5:2] is decoded.
- NUM_PINS, 8, number of user I/O pins; legal range 1..32.
- SYNC_STAGES, 2, input synchroniser depth; legal range 2..4.
- DEB_WIDTH, 8, width of the debounce threshold and per-pin counters.

Ports:
- clk_i  in  1  single clock; every flop is on its rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- PADDR  in  APB_ADDR_WIDTH  APB address.
- PWDATA  in  32  APB write data.
- PWRITE  in  1  APB write strobe.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PRDATA  out  32  APB read data.
- PREADY  out  1  tied to 1.
- PSLVERR  out  1  error for an unmapped offset.
- upio_in_i  in  NUM_PINS  asynchronous pin inputs.
- upio_out_o  out  NUM_PINS  pin output values (OUT register).
- upio_dir_o  out  NUM_PINS  pin direction; 1 = output (DIR register).
- int_o  out  1  registered OR of the STATUS register.

## Operation
- Access phase is PSEL & PENABLE. Writes commit at the clock edge of the access phase. PRDATA and PSLVERR are combinational in the access phase. Reads zero-extend to 32 bits. Writes use PWDATA[NUM_PINS-1:0] only.
- Register map (byte offsets):
  - 0x00 DIR, RW.
  - 0x04 OUT, RW.
  - 0x08 IN, RO: debounced value.
  - 0x0C SET, WO: OUT |= wdata.
  - 0x10 CLR, WO: OUT &= ~wdata.
  - 0x14 RISE_EN, RW.
  - 0x18 FALL_EN, RW.
  - 0x1C STATUS, RW1C.
  - 0x20 DEB_CNT, RW, DEB_WIDTH bits.
- SET and CLR read as 0. Any other offset: PSLVERR=1, PRDATA=0, no state change.
- Synchroniser: a SYNC_STAGES-deep flop chain per pin produces sync[i].
- Debounce, per pin, with filtered value filt[i] and counter cnt[i]:
  - If sync[i]==filt[i], then cnt[i]<=0.
  - Else if cnt[i]==DEB_CNT, then filt[i]<=sync[i] and cnt[i]<=0.
  - Else cnt[i]<=cnt[i]+1.
  - DEB_CNT=0 therefore means filt follows sync with 1 cycle of delay. The counter never exceeds DEB_CNT, so it never wraps.
- A write to DEB_CNT clears all cnt[i] in the same edge. filt is unchanged.
- Edge detect uses filt_d, the previous filt value:
  - rise[i] = filt[i] & ~filt_d[i] & RISE_EN[i]
  - fall[i] = ~filt[i] & filt_d[i] & FALL_EN[i]
- STATUS[i] <= (STATUS[i] & ~w1c[i]) | rise[i] | fall[i]. On a simultaneous set and clear, the set wins.
- Clearing RISE_EN or FALL_EN does not clear STATUS bits that are already set.
- SET and CLR written with overlapping bits is impossible, since they are different addresses. A DIR or OUT write always overwrites the whole register.
- int_o <= |STATUS (registered).

## Timing
- Reset (rst_i=1 at an edge) clears DIR, OUT, RISE_EN, FALL_EN, STATUS, DEB_CNT, the synchroniser chains, filt, filt_d, cnt and int_o.
  - upio_out_o=0, upio_dir_o=0, int_o=0.
  - PRDATA=0 and PSLVERR=0 when not in the access phase.
  - PREADY=1 always.
- Reset asserted mid-debounce aborts the count. No edge is reported for the aborted count.
- A pin held high through reset produces a rise on filt afterwards. It sets STATUS only if RISE_EN is already 1, and RISE_EN is 0 after reset.
- Latency from a stable pin change to the IN register update: SYNC_STAGES + DEB_CNT + 1 cycles.
- STATUS sets 1 cycle after filt changes. int_o rises 1 cycle after STATUS.
- After a W1C that clears the last STATUS bit, int_o falls 1 cycle after the write edge.
- A glitch shorter than DEB_CNT+1 synchronised cycles never reaches filt.
- OUT and DIR drive the pins 0 cycles after the write edge (register outputs).

## Test plan
- Reset, then read all offsets: every register reads 0. Offset 0x24 returns PSLVERR=1 and PRDATA=0. upio_out_o=0, upio_dir_o=0, int_o=0.
- Write OUT=0xA5, SET 0x0F, CLR 0x81: upio_out_o goes 0xA5 -> 0xAF -> 0x2E, each update one edge after its write. DIR=0xFF gives upio_dir_o=0xFF.
- DEB_CNT=3, RISE_EN=0x01, pin0 0->1 held: IN[0]=1 exactly SYNC_STAGES+4 cycles after the change; STATUS=0x01 one cycle later; int_o=1 one cycle after that.
- DEB_CNT=3, pin1 pulsed high for 3 cycles, RISE_EN=FALL_EN=0x02: IN and STATUS never change, int_o stays 0.
- With STATUS[2] pending, write STATUS=0x04 in the same cycle a new fall on pin2 sets it: STATUS[2] stays 1 and int_o stays 1. A second W1C clears it, and int_o=0 one cycle later.
- NUM_PINS=32, DEB_CNT=0: toggle all pins and assert rst_i mid-activity. All outputs, including int_o, read 0 after the reset edge. Rerun the edge tests on bit 31 with no width truncation.
